// File: rtl/counter_4b_pkg.sv
// rtl/counter_4b_pkg.sv - mode constants, FSM encoding and step/wrap rules for the 4-bit mode counter
package counter_4b_pkg;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LWAIT = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] step(input logic [1:0] mode, input logic [3:0] q);
        case (mode)
            MODE_UP:    step = q + 4'd1;
            MODE_DOWN:  step = q - 4'd1;
            MODE_DOWN3: step = q - 4'd3;
            default:    step = q;
        endcase
    endfunction

    // True when stepping away from q crosses the 0/15 boundary.
    function automatic logic wrap_cond(input logic [1:0] mode, input logic [3:0] q);
        case (mode)
            MODE_UP:    wrap_cond = (q == 4'd15);
            MODE_DOWN:  wrap_cond = (q == 4'd0);
            MODE_DOWN3: wrap_cond = (q <= 4'd2);
            default:    wrap_cond = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/counter_4b_model.sv
// rtl/counter_4b_model.sv - expected-Q tracker; seeds one step past the load value, then advances per cycle
module counter_4b_model
    import counter_4b_pkg::*;
(
    input  logic       clk,
    input  logic       RESET,
    input  logic [1:0] mode,
    input  logic       seed_en,
    input  logic [3:0] seed_q,
    input  logic       adv_en,
    output logic [3:0] exp_q,
    output logic [3:0] exp_next,
    output logic       wrap
);

    assign exp_next = step(mode, exp_q);
    assign wrap     = wrap_cond(mode, exp_q);

    always_ff @(posedge clk) begin
        if (RESET) begin
            exp_q <= 4'd0;
        end else if (seed_en) begin
            exp_q <= step(mode, seed_q);
        end else if (adv_en) begin
            exp_q <= exp_next;
        end
    end

endmodule

// File: rtl/counter_4b_ctrl.sv
// rtl/counter_4b_ctrl.sv - command driver/checker for the 4-bit mode counter
// CTRL_ERR_HALT_EN: when defined, the first mismatch ends the command immediately.
module counter_4b_ctrl
    import counter_4b_pkg::*;
#(
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [3:0]        cmd_data,
    input  logic [WRAP_W-1:0] cmd_wraps,
    input  logic [3:0]        ctr_q,
    input  logic              ctr_load,
    output logic              ENABLE,
    output logic [1:0]        MODO,
    output logic [3:0]        D,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err
);

`ifdef CTRL_ERR_HALT_EN
    localparam bit HALT_ON_ERR = 1'b1;
`else
    localparam bit HALT_ON_ERR = 1'b0;
`endif

    // One extra bit so a zero wrap request can mean the full 2^WRAP_W.
    localparam logic [WRAP_W:0] FULL_RANGE = {1'b1, {WRAP_W{1'b0}}};

    state_t          state;
    logic [1:0]      mode_r;
    logic [3:0]      data_r;
    logic [WRAP_W:0] target_r;
    logic [WRAP_W:0] seen_r;
    logic [WRAP_W:0] seen_next;
    logic [3:0]      exp_q;
    logic [3:0]      exp_next;
    logic            wrap;
    logic            accept;
    logic            lwait_bad;
    logic            run_bad;
    logic            run_halt;
    logic            run_hit;

    counter_4b_model u_model (
        .clk      (clk),
        .RESET    (RESET),
        .mode     (mode_r),
        .seed_en  (state == S_LWAIT),
        .seed_q   (data_r),
        .adv_en   (state == S_RUN),
        .exp_q    (exp_q),
        .exp_next (exp_next),
        .wrap     (wrap)
    );

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign lwait_bad = !ctr_load || (ctr_q != data_r);
    assign run_bad   = ctr_load || (ctr_q != exp_q);
    assign run_halt  = HALT_ON_ERR && run_bad;
    assign seen_next = seen_r + 1'b1;
    assign run_hit   = wrap && (seen_next == target_r);
    assign wrap_cnt  = seen_r[WRAP_W] ? {WRAP_W{1'b1}} : seen_r[WRAP_W-1:0];

    always_ff @(posedge clk) begin
        if (RESET) begin
            state    <= S_IDLE;
            ENABLE   <= 1'b0;
            MODO     <= MODE_UP;
            D        <= 4'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            seen_r   <= '0;
            mode_r   <= MODE_UP;
            data_r   <= 4'd0;
            target_r <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ENABLE <= 1'b0;
                    if (accept) begin
                        mode_r   <= cmd_mode;
                        data_r   <= cmd_data;
                        target_r <= (cmd_wraps == '0) ? FULL_RANGE : {1'b0, cmd_wraps};
                        err      <= 1'b0;
                        seen_r   <= '0;
                        ENABLE   <= 1'b1;
                        MODO     <= MODE_LOAD;
                        D        <= cmd_data;
                        state    <= S_LOAD;
                    end
                end
                // The counter must already see the run mode during LWAIT so that
                // its first step lands on the first RUN cycle.
                S_LOAD: begin
                    MODO  <= mode_r;
                    state <= S_LWAIT;
                end
                S_LWAIT: begin
                    if (lwait_bad) begin
                        err <= 1'b1;
                    end
                    if ((mode_r == MODE_LOAD) || (HALT_ON_ERR && lwait_bad)) begin
                        ENABLE <= 1'b0;
                        MODO   <= MODE_UP;
                        D      <= 4'd0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_bad) begin
                        err <= 1'b1;
                    end
                    if (wrap && !run_halt) begin
                        seen_r <= seen_next;
                    end
                    if (run_halt || run_hit) begin
                        ENABLE <= 1'b0;
                        MODO   <= MODE_UP;
                        D      <= 4'd0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_4b_ctrl.sv
// tb/tb_counter_4b_ctrl.sv - self-checking bench: table vectors, corner sequences and random commands
module tb_counter_4b_ctrl;

`ifdef CTRL_ERR_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [3:0] cmd_wraps;
    logic [3:0] ctr_q;
    logic       ctr_load;
    logic       ENABLE;
    logic [1:0] MODO;
    logic [3:0] D;
    logic       busy;
    logic       done;
    logic [3:0] wrap_cnt;
    logic       err;

    logic [3:0] cq;
    logic       ctr_fault;
    int         checks = 0;
    int         errors = 0;
    int         accept_cnt = 0;

    always #5 clk = ~clk;

    counter_4b_ctrl #(.WRAP_W(4)) dut (
        .clk(clk), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_wraps(cmd_wraps),
        .ctr_q(ctr_q), .ctr_load(ctr_load), .ENABLE(ENABLE), .MODO(MODO), .D(D),
        .busy(busy), .done(done), .wrap_cnt(wrap_cnt), .err(err)
    );

    // Behavioural 4-bit mode counter: loads on MODO=11, steps otherwise, clears when disabled.
    always @(posedge clk) begin
        if (RESET) begin
            cq <= 4'd0; ctr_load <= 1'b0;
        end else if (!ENABLE) begin
            cq <= 4'd0; ctr_load <= 1'b0;
        end else begin
            ctr_load <= (MODO == 2'b11);
            case (MODO)
                2'b00:   cq <= cq + 4'd1;
                2'b01:   cq <= cq + 4'd15;
                2'b10:   cq <= cq + 4'd13;
                default: cq <= D;
            endcase
        end
    end
    assign ctr_q = ctr_fault ? 4'd7 : cq;

    always @(posedge clk) if (!RESET && cmd_valid && cmd_ready) accept_cnt <= accept_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walks the value sequence the counter must show and counts boundary crossings.
    function automatic void ref_run(input int m, input int d, input int w, input int fault_run,
                                    output int n, output int wraps, output bit e);
        int delta, v, target;
        n = 0; wraps = 0; e = 1'b0;
        if (m == 3) return;
        delta  = (m == 0) ? 1 : (m == 1) ? 15 : 13;
        target = (w == 0) ? 16 : w;
        v      = (d + delta) % 16;
        for (int k = 0; k < 1000; k++) begin
            n++;
            if (n == fault_run && v != 7) begin
                e = 1'b1;
                if (HALT) return;
            end
            if ((m == 0 && v == 15) || (m == 1 && v == 0) || (m == 2 && v < 3)) begin
                wraps++;
                if (wraps == target) return;
            end
            v = (v + delta) % 16;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (cycle 1 = first after accept).
    task automatic run_cmd(input int m, input int d, input int w, input int fault_run, input bit keep_valid,
                           output int done_c, output int en_cycles, output int wc, output int e, output int waits);
        int c;
        cmd_valid = 1'b1; cmd_mode = 2'(m); cmd_data = 4'(d); cmd_wraps = 4'(w);
        waits = 0; done_c = -1; en_cycles = 0; wc = -1; e = -1;
        while (!cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
        c = 1;
        while (c <= 400) begin
            ctr_fault = (fault_run > 0) && (c == fault_run + 2);
            if (ENABLE) en_cycles++;
            if (done) begin
                done_c = c; wc = int'(wrap_cnt); e = int'(err);
                break;
            end
            @(negedge clk);
            c++;
        end
        ctr_fault = 1'b0;
        if (done_c < 0) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        int m; int d; int w; int fault_run;
        int n; int wc; int e;
    } vec_t;

    vec_t tbl[7];
    int   done_c, en_c, wc, e, waits, n, wr, acc0;
    bit   eb;

    initial begin
        tbl[0] = '{0, 14, 1, 0, 1, 1, 0};
        tbl[1] = '{2, 5, 2, 0, 7, 2, 0};
        tbl[2] = '{3, 9, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 1, 0, 16, 1, 0};
        if (HALT) tbl[4] = '{0, 3, 1, 2, 2, 0, 1};
        else      tbl[4] = '{0, 3, 1, 2, 12, 1, 1};
        tbl[5] = '{0, 15, 0, 0, 256, 15, 0};
        tbl[6] = '{2, 0, 1, 0, 5, 1, 0};

        RESET = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_data = 4'd0; cmd_wraps = 4'd0;
        ctr_fault = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_enable", int'(ENABLE), 0);
        chk("rst_modo", int'(MODO), 0);
        chk("rst_d", int'(D), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_wrap_cnt", int'(wrap_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        RESET = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_cmd(tbl[i].m, tbl[i].d, tbl[i].w, tbl[i].fault_run, 1'b0, done_c, en_c, wc, e, waits);
            chk($sformatf("tbl%0d_done_cycle", i), done_c, tbl[i].n + 3);
            chk($sformatf("tbl%0d_enable_cycles", i), en_c, tbl[i].n + 2);
            chk($sformatf("tbl%0d_wrap_cnt", i), wc, tbl[i].wc);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
            @(negedge clk);
            chk($sformatf("tbl%0d_idle_ready", i), int'(cmd_ready), 1);
            chk($sformatf("tbl%0d_idle_wrap_hold", i), int'(wrap_cnt), tbl[i].wc);
            chk($sformatf("tbl%0d_idle_done_low", i), int'(done), 0);
        end

        // Reset in the middle of a run, after one wrap has been counted.
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_data = 4'd14; cmd_wraps = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy", int'(busy), 1);
        chk("midrun_wrap_cnt", int'(wrap_cnt), 1);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        chk("postrst_enable", int'(ENABLE), 0);
        chk("postrst_modo", int'(MODO), 0);
        chk("postrst_d", int'(D), 0);
        chk("postrst_wrap_cnt", int'(wrap_cnt), 0);
        chk("postrst_err", int'(err), 0);
        chk("postrst_busy", int'(busy), 0);
        chk("postrst_ready", int'(cmd_ready), 1);
        run_cmd(2, 5, 2, 0, 1'b0, done_c, en_c, wc, e, waits);
        chk("postrst_cmd_done_cycle", done_c, 10);
        chk("postrst_cmd_wrap_cnt", wc, 2);
        @(negedge clk);

        // cmd_valid held high across two commands.
        acc0 = accept_cnt;
        run_cmd(0, 14, 1, 0, 1'b1, done_c, en_c, wc, e, waits);
        chk("hs_first_wait", waits, 0);
        chk("hs_first_done_cycle", done_c, 4);
        chk("hs_accepts_during_busy", accept_cnt - acc0, 1);
        run_cmd(3, 9, 0, 0, 1'b0, done_c, en_c, wc, e, waits);
        chk("hs_second_wait", waits, 1);
        chk("hs_second_done_cycle", done_c, 3);
        chk("hs_total_accepts", accept_cnt - acc0, 2);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            int rm, rd, rw, rf;
            rm = $urandom_range(0, 3);
            rd = $urandom_range(0, 15);
            rw = $urandom_range(0, 15);
            rf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            ref_run(rm, rd, rw, rf, n, wr, eb);
            run_cmd(rm, rd, rw, rf, 1'b0, done_c, en_c, wc, e, waits);
            chk($sformatf("rnd%0d_m%0d_d%0d_w%0d_done_cycle", i, rm, rd, rw), done_c, n + 3);
            chk($sformatf("rnd%0d_enable_cycles", i), en_c, n + 2);
            chk($sformatf("rnd%0d_wrap_cnt", i), wc, (wr > 15) ? 15 : wr);
            chk($sformatf("rnd%0d_err", i), e, int'(eb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
